alu_issue_stage: RTL and testbench
==================================

# alu_issue_stage

Issue register stage that sits directly in front of the execute-stage ALU. It decodes a MIPS instruction word into the ALU's 4-bit `AluControl` code, shift amount, and operand pair, then buffers the result in a 2-entry skid queue. A valid/ready handshake on both sides lets the ALU side stall without a combinational ready path back to decode.

## Interface
Parameters:
- `DEPTH`, 2: queue entries. Fixed at 2; any other value is unsupported.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `resetn`  in  1  synchronous, active-low reset.
- `flush`  in  1  synchronous queue clear, e.g. on a branch mispredict.
- `in_valid`  in  1  decode side presents an instruction.
- `in_ready`  out  1  stage can accept an instruction this cycle.
- `instr`  in  32  instruction word.
- `rs_val`  in  32  register-file value for rs.
- `rt_val`  in  32  register-file value for rt.
- `out_valid`  out  1  head entry is valid.
- `out_ready`  in  1  ALU side consumes the head entry.
- `SrcA`, `SrcB`  out  32  ALU operands.
- `Sa`  out  5  shift amount.
- `AluControl`  out  4  ALU operation code.
- `dest`  out  5  destination register number.
- `ill`  out  1  instruction is not supported by the ALU.

## Operation
- The decode step is combinational on `instr`. Its result is written into the queue on accept.
- R-type instructions (opcode 000000): `SrcA`=`rs_val`, `SrcB`=`rt_val`, `Sa`=`instr[10:6]`, `dest`=`instr[15:11]`. Funct mapping:
  - add/addu (100000/100001) → 0010
  - sub/subu (100010/100011) → 0110
  - and (100100) → 0000
  - or (100101) → 0001
  - xor (100110) → 0011
  - sltu (101011) → 0111
  - sll (000000) → 0100
  - sllv (000100) → 0101
  - srl (000010) → 1000
  - srlv (000110) → 1001
  - sra (000011) → 1010
  - srav (000111) → 1011
- I-type instructions: `SrcA`=`rs_val`, `Sa`=0, `dest`=`instr[20:16]`. Opcode mapping:
  - addi/addiu (001000/001001) → 0010, `SrcB`=sign-extended imm
  - andi (001100) → 0000, `SrcB`=zero-extended imm
  - ori (001101) → 0001, `SrcB`=zero-extended imm
  - xori (001110) → 0011, `SrcB`=zero-extended imm
  - sltiu (001011) → 0111, `SrcB`=sign-extended imm
  - lui (001111) → 1100, `SrcB`={imm,16'h0000}
- The ALU compare is unsigned only, so slt and slti are unsupported.
- Any other opcode/funct, including slt and slti: `AluControl`=1111, `ill`=1, `dest`=0, operands are still captured. The ALU outputs 0 for code 1111.
- Queue state: an occupancy count (0..2) plus head and tail entries. `in_ready` = (count != 2) and is driven from registered state only.
- Accept condition: `in_valid && in_ready`. Pop condition: `out_valid && out_ready`. `out_valid` = (count != 0).
- Accept and pop in the same cycle: count is unchanged and FIFO order is preserved.
- `flush` has priority over accept and pop. It sets count to 0, and an instruction offered in the same cycle is dropped.

## Timing
- Reset (`resetn`=0 at an edge) sets count=0 and clears all entry fields to 0.
  - After that edge: `out_valid`=0, `SrcA`=`SrcB`=0, `Sa`=0, `AluControl`=0000, `dest`=0, `ill`=0, `in_ready`=1.
  - While `resetn` is low, `in_ready` is forced to 0.
- Reset asserted mid-operation discards all queued entries at that edge. No partial pop occurs.
- Latency: an instruction accepted at edge N appears on the outputs with `out_valid`=1 from edge N, i.e. visible in cycle N+1. There is no bypass from input to output in the same cycle.
- Throughput: 1 instruction/cycle with `out_ready` held high.
- With `out_ready`=0, up to 2 instructions are absorbed. `in_ready` drops in the cycle after the second accept.
- When the count is 2 and a pop occurs, `in_ready` rises in the following cycle.
- Output fields are stable while `out_valid && !out_ready`.
- When the queue is empty, output fields hold their last values; `out_valid` qualifies them.

## Test plan
- Reset then idle: `resetn`=0 for 2 cycles → `out_valid`=0, `AluControl`=0000, `in_ready`=1 after release.
- Drive addiu with imm=16'hFFFF, `rs_val`=5, `out_ready`=1 → next cycle `AluControl`=0010, `SrcB`=32'hFFFFFFFF, `dest`=rt, `ill`=0.
- Drive sra with shamt 4, `rt_val`=32'h80000000 → `AluControl`=1010, `Sa`=4. Drive lui with imm=16'h1234 → `SrcB`=32'h12340000, `AluControl`=1100.
- Backpressure: `out_ready`=0, offer 3 instructions back-to-back → first 2 accepted, `in_ready`=0, third held. Raise `out_ready` → all three emerge in order.
- Flush while count=2 and `in_valid`=1 → next cycle `out_valid`=0, count 0, offered instruction never appears.
- Illegal slt (funct 101010) → `AluControl`=1111, `ill`=1, `dest`=0. `resetn` pulsed with 2 queued entries → queue empty next cycle.

Source files
------------

// File: rtl/alu_issue_stage_if.sv
// Handshake and data bundle between decode, the ALU issue stage and the ALU.
// The master side drives instructions in and consumes decoded entries;
// the slave side is the issue stage itself.
interface alu_issue_stage_if;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic [4:0]  Sa;
    logic [3:0]  AluControl;
    logic [4:0]  dest;
    logic        ill;

    modport master (
        output flush, in_valid, instr, rs_val, rt_val, out_ready,
        input  in_ready, out_valid, SrcA, SrcB, Sa, AluControl, dest, ill
    );

    modport slave (
        input  flush, in_valid, instr, rs_val, rt_val, out_ready,
        output in_ready, out_valid, SrcA, SrcB, Sa, AluControl, dest, ill
    );
endinterface

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes a MIPS instruction into ALU control, shift amount,
// destination and operands, then buffers the result in a 2-entry skid queue.
// in_ready depends only on the registered occupancy (and reset), so the ALU
// side can stall without a combinational path back into decode.
module alu_issue_stage #(
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              resetn,
    alu_issue_stage_if.slave  bus
);

    localparam logic [1:0] FULL = 2'(DEPTH);

    localparam logic [3:0] CTL_ILL = 4'b1111;

    typedef struct packed {
        logic [31:0] src_a;
        logic [31:0] src_b;
        logic [4:0]  sa;
        logic [3:0]  alu_control;
        logic [4:0]  dest;
        logic        ill;
    } entry_t;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [3:0]  ctl;
    logic        is_rtype;
    entry_t      dec;
    entry_t      head;
    entry_t      tail;
    logic [1:0]  count;
    logic        in_ready;
    logic        out_valid;
    logic        accept;
    logic        pop;
    logic        unused_rs_field;

    assign opcode   = bus.instr[31:26];
    assign funct    = bus.instr[5:0];
    assign imm      = bus.instr[15:0];
    assign is_rtype = (opcode == 6'b000000);

    // The rs register number is resolved upstream; only its value arrives here.
    assign unused_rs_field = ^bus.instr[25:21];

    // Decode the instruction word into an entry; anything the ALU cannot run
    // gets code 1111 with dest forced to 0 so it never writes back.
    always_comb begin
        ctl       = CTL_ILL;
        dec.src_a = bus.rs_val;
        dec.src_b = bus.rt_val;
        dec.sa    = 5'd0;
        if (is_rtype) begin
            dec.sa = bus.instr[10:6];
            case (funct)
                6'b100000, 6'b100001: ctl = 4'b0010;
                6'b100010, 6'b100011: ctl = 4'b0110;
                6'b100100:            ctl = 4'b0000;
                6'b100101:            ctl = 4'b0001;
                6'b100110:            ctl = 4'b0011;
                6'b101011:            ctl = 4'b0111;
                6'b000000:            ctl = 4'b0100;
                6'b000100:            ctl = 4'b0101;
                6'b000010:            ctl = 4'b1000;
                6'b000110:            ctl = 4'b1001;
                6'b000011:            ctl = 4'b1010;
                6'b000111:            ctl = 4'b1011;
                default:              ctl = CTL_ILL;
            endcase
        end else begin
            case (opcode)
                6'b001000, 6'b001001: begin
                    ctl       = 4'b0010;
                    dec.src_b = {{16{imm[15]}}, imm};
                end
                6'b001100: begin
                    ctl       = 4'b0000;
                    dec.src_b = {16'h0000, imm};
                end
                6'b001101: begin
                    ctl       = 4'b0001;
                    dec.src_b = {16'h0000, imm};
                end
                6'b001110: begin
                    ctl       = 4'b0011;
                    dec.src_b = {16'h0000, imm};
                end
                6'b001011: begin
                    ctl       = 4'b0111;
                    dec.src_b = {{16{imm[15]}}, imm};
                end
                6'b001111: begin
                    ctl       = 4'b1100;
                    dec.src_b = {imm, 16'h0000};
                end
                default: ctl = CTL_ILL;
            endcase
        end
        dec.alu_control = ctl;
        dec.ill         = (ctl == CTL_ILL);
        if (ctl == CTL_ILL) begin
            dec.dest = 5'd0;
        end else if (is_rtype) begin
            dec.dest = bus.instr[15:11];
        end else begin
            dec.dest = bus.instr[20:16];
        end
    end

    assign in_ready  = resetn && (count != FULL);
    assign out_valid = (count != 2'd0);
    assign accept    = bus.in_valid && in_ready;
    assign pop       = out_valid && bus.out_ready;

    // Queue update: head always feeds the outputs, tail holds the second entry.
    // The head is only overwritten when a new entry becomes the head, so an
    // empty queue keeps presenting the last head it held.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            count <= 2'd0;
            head  <= '0;
            tail  <= '0;
        end else if (bus.flush) begin
            count <= 2'd0;
        end else begin
            case ({accept, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        head <= dec;
                    end else begin
                        tail <= dec;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    if (count == 2'd2) begin
                        head <= tail;
                    end
                    count <= count - 2'd1;
                end
                2'b11: begin
                    // Only reachable with one entry: the new one replaces the head.
                    head <= dec;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid;
    assign bus.SrcA       = head.src_a;
    assign bus.SrcB       = head.src_b;
    assign bus.Sa         = head.sa;
    assign bus.AluControl = head.alu_control;
    assign bus.dest       = head.dest;
    assign bus.ill        = head.ill;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed scenarios followed by a
// randomized run against a queue-based reference model.
module tb_alu_issue_stage;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    alu_issue_stage_if bus ();

    alu_issue_stage #(.DEPTH(2)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sa;
        logic [3:0]  ctl;
        logic [4:0]  dest;
        logic        ill;
    } exp_t;

    // Step one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] r_instr(input logic [4:0] rd, input logic [4:0] rs,
                                            input logic [4:0] rt, input logic [4:0] sh,
                                            input logic [5:0] fn);
        return {6'b000000, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] i_instr(input logic [5:0] op, input logic [4:0] rs,
                                            input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Reference decode from the instruction tables.
    function automatic exp_t model_decode(input logic [31:0] ins, input logic [31:0] rs,
                                          input logic [31:0] rt);
        exp_t e;
        int   code;
        logic [31:0] sext;
        logic [31:0] zext;
        sext = 32'($signed(ins[15:0]));
        zext = {16'h0, ins[15:0]};
        code = -1;
        e.a = rs;
        e.b = rt;
        e.sa = 5'd0;
        if (ins[31:26] == 6'd0) begin
            e.sa = ins[10:6];
            case (ins[5:0])
                6'h20, 6'h21: code = 2;
                6'h22, 6'h23: code = 6;
                6'h24: code = 0;
                6'h25: code = 1;
                6'h26: code = 3;
                6'h2b: code = 7;
                6'h00: code = 4;
                6'h04: code = 5;
                6'h02: code = 8;
                6'h06: code = 9;
                6'h03: code = 10;
                6'h07: code = 11;
                default: code = -1;
            endcase
            e.dest = ins[15:11];
        end else begin
            case (ins[31:26])
                6'h08, 6'h09: begin code = 2;  e.b = sext; end
                6'h0c:        begin code = 0;  e.b = zext; end
                6'h0d:        begin code = 1;  e.b = zext; end
                6'h0e:        begin code = 3;  e.b = zext; end
                6'h0b:        begin code = 7;  e.b = sext; end
                6'h0f:        begin code = 12; e.b = ins[15:0] << 16; end
                default:      code = -1;
            endcase
            e.dest = ins[20:16];
        end
        e.ill = (code < 0);
        e.ctl = e.ill ? 4'hF : 4'(code);
        if (e.ill) e.dest = 5'd0;
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [5:0] fn_tab [15] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                                    6'h2b, 6'h00, 6'h04, 6'h02, 6'h06, 6'h03, 6'h07, 6'h2a};
        logic [5:0] op_tab [8] = '{6'h08, 6'h09, 6'h0c, 6'h0d, 6'h0e, 6'h0b, 6'h0f, 6'h0a};
        logic [31:0] ins;
        ins = $urandom;
        case ($urandom_range(0, 4))
            0, 1, 2: begin
                ins[31:26] = 6'd0;
                if ($urandom_range(0, 9) == 0) ins[5:0] = 6'($urandom);
                else ins[5:0] = fn_tab[$urandom_range(0, 14)];
            end
            default: begin
                if ($urandom_range(0, 9) == 0) ins[31:26] = 6'($urandom_range(1, 63));
                else ins[31:26] = op_tab[$urandom_range(0, 7)];
            end
        endcase
        return ins;
    endfunction

    // Reset held for two cycles, then released into an idle, empty stage.
    task automatic test_reset();
        resetn = 1'b0;
        tick();
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_in_ready_low got=%b want=0", bus.in_ready); end
        tick();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid got=%b want=0", bus.out_valid); end
        total++; if (bus.AluControl !== 4'h0) begin bad++; $display("[TB] FAIL reset_ctl got=%h want=0", bus.AluControl); end
        total++; if (bus.SrcA !== 32'h0 || bus.SrcB !== 32'h0) begin bad++; $display("[TB] FAIL reset_src got=%h/%h want=0/0", bus.SrcA, bus.SrcB); end
        total++; if (bus.Sa !== 5'd0 || bus.dest !== 5'd0 || bus.ill !== 1'b0) begin bad++; $display("[TB] FAIL reset_fields got sa=%0d dest=%0d ill=%b want 0", bus.Sa, bus.dest, bus.ill); end
        resetn = 1'b1;
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_release_in_ready got=%b want=1", bus.in_ready); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_release_out_valid got=%b want=0", bus.out_valid); end
    endtask

    // addiu with an all-ones immediate must sign-extend.
    task automatic test_addiu();
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.instr = i_instr(6'h09, 5'd1, 5'd7, 16'hFFFF);
        bus.rs_val = 32'd5;
        bus.rt_val = 32'hDEAD;
        tick();
        bus.in_valid = 1'b0;
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("[TB] FAIL addiu_valid got=%b want=1", bus.out_valid); end
        total++; if (bus.AluControl !== 4'b0010) begin bad++; $display("[TB] FAIL addiu_ctl got=%h want=2", bus.AluControl); end
        total++; if (bus.SrcB !== 32'hFFFFFFFF) begin bad++; $display("[TB] FAIL addiu_srcb got=%h want=ffffffff", bus.SrcB); end
        total++; if (bus.SrcA !== 32'd5) begin bad++; $display("[TB] FAIL addiu_srca got=%h want=5", bus.SrcA); end
        total++; if (bus.dest !== 5'd7 || bus.ill !== 1'b0) begin bad++; $display("[TB] FAIL addiu_dest got dest=%0d ill=%b want 7/0", bus.dest, bus.ill); end
        tick();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL addiu_drain got=%b want=0", bus.out_valid); end
    endtask

    // sra followed back-to-back by lui with the ALU consuming every cycle.
    task automatic test_sra_lui();
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.instr = r_instr(5'd4, 5'd2, 5'd3, 5'd4, 6'h03);
        bus.rs_val = 32'd1;
        bus.rt_val = 32'h80000000;
        tick();
        bus.instr = i_instr(6'h0f, 5'd0, 5'd12, 16'h1234);
        bus.rs_val = 32'd0;
        bus.rt_val = 32'd0;
        total++; if (bus.AluControl !== 4'b1010) begin bad++; $display("[TB] FAIL sra_ctl got=%h want=a", bus.AluControl); end
        total++; if (bus.Sa !== 5'd4) begin bad++; $display("[TB] FAIL sra_sa got=%0d want=4", bus.Sa); end
        total++; if (bus.SrcB !== 32'h80000000 || bus.dest !== 5'd4) begin bad++; $display("[TB] FAIL sra_op got srcb=%h dest=%0d want 80000000/4", bus.SrcB, bus.dest); end
        tick();
        bus.in_valid = 1'b0;
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("[TB] FAIL lui_valid got=%b want=1", bus.out_valid); end
        total++; if (bus.SrcB !== 32'h12340000) begin bad++; $display("[TB] FAIL lui_srcb got=%h want=12340000", bus.SrcB); end
        total++; if (bus.AluControl !== 4'b1100 || bus.dest !== 5'd12 || bus.Sa !== 5'd0) begin bad++; $display("[TB] FAIL lui_fields got ctl=%h dest=%0d sa=%0d want c/12/0", bus.AluControl, bus.dest, bus.Sa); end
        tick();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL lui_drain got=%b want=0", bus.out_valid); end
    endtask

    // Three offers against a stalled ALU: two absorbed, third waits, order kept.
    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.rs_val = 32'd11;
        bus.rt_val = 32'd12;
        bus.instr = r_instr(5'd1, 5'd0, 5'd0, 5'd0, 6'h21);
        tick();
        total++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b1) begin bad++; $display("[TB] FAIL bp_one got in_ready=%b out_valid=%b want 1/1", bus.in_ready, bus.out_valid); end
        bus.instr = r_instr(5'd2, 5'd0, 5'd0, 5'd0, 6'h23);
        tick();
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_full got=%b want=0", bus.in_ready); end
        bus.instr = r_instr(5'd3, 5'd0, 5'd0, 5'd0, 6'h24);
        tick();
        total++; if (bus.in_ready !== 1'b0 || bus.dest !== 5'd1 || bus.AluControl !== 4'b0010) begin bad++; $display("[TB] FAIL bp_hold got in_ready=%b dest=%0d ctl=%h want 0/1/2", bus.in_ready, bus.dest, bus.AluControl); end
        bus.out_ready = 1'b1;
        tick();
        total++; if (bus.dest !== 5'd2 || bus.AluControl !== 4'b0110 || bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL bp_second got dest=%0d ctl=%h in_ready=%b want 2/6/1", bus.dest, bus.AluControl, bus.in_ready); end
        tick();
        bus.in_valid = 1'b0;
        total++; if (bus.dest !== 5'd3 || bus.AluControl !== 4'b0000 || bus.out_valid !== 1'b1) begin bad++; $display("[TB] FAIL bp_third got dest=%0d ctl=%h valid=%b want 3/0/1", bus.dest, bus.AluControl, bus.out_valid); end
        tick();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_drain got=%b want=0", bus.out_valid); end
    endtask

    // Flush empties a full queue and also drops an instruction offered alongside it.
    task automatic test_flush();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.instr = r_instr(5'd5, 5'd0, 5'd0, 5'd0, 6'h26);
        tick();
        bus.instr = r_instr(5'd6, 5'd0, 5'd0, 5'd0, 6'h25);
        tick();
        bus.instr = i_instr(6'h0d, 5'd0, 5'd8, 16'h00FF);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL flush_full got valid=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready); end
        bus.out_ready = 1'b1;
        tick();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL flush_full_after got=%b want=0", bus.out_valid); end
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.instr = i_instr(6'h0e, 5'd0, 5'd9, 16'h0F0F);
        tick();
        bus.instr = i_instr(6'h08, 5'd0, 5'd10, 16'h0001);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL flush_drop got=%b want=0", bus.out_valid); end
        tick();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL flush_drop_after got=%b want=0", bus.out_valid); end
    endtask

    // slt/slti are rejected; a reset pulse discards two queued entries.
    task automatic test_illegal_reset();
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.rs_val = 32'h0000ABCD;
        bus.instr = r_instr(5'd9, 5'd1, 5'd2, 5'd0, 6'h2a);
        tick();
        bus.instr = i_instr(6'h0a, 5'd1, 5'd11, 16'h0004);
        total++; if (bus.AluControl !== 4'hF || bus.ill !== 1'b1) begin bad++; $display("[TB] FAIL slt_ctl got ctl=%h ill=%b want f/1", bus.AluControl, bus.ill); end
        total++; if (bus.dest !== 5'd0 || bus.SrcA !== 32'h0000ABCD) begin bad++; $display("[TB] FAIL slt_dest got dest=%0d srca=%h want 0/0000abcd", bus.dest, bus.SrcA); end
        tick();
        bus.in_valid = 1'b0;
        total++; if (bus.AluControl !== 4'hF || bus.ill !== 1'b1 || bus.dest !== 5'd0) begin bad++; $display("[TB] FAIL slti got ctl=%h ill=%b dest=%0d want f/1/0", bus.AluControl, bus.ill, bus.dest); end
        tick();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.instr = r_instr(5'd13, 5'd0, 5'd0, 5'd0, 6'h2b);
        tick();
        bus.instr = i_instr(6'h0f, 5'd0, 5'd14, 16'h5555);
        tick();
        bus.in_valid = 1'b0;
        total++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin bad++; $display("[TB] FAIL rst_prefill got in_ready=%b valid=%b want 0/1", bus.in_ready, bus.out_valid); end
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        #1;
        total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL rst_pulse got valid=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready); end
        total++; if (bus.AluControl !== 4'h0 || bus.dest !== 5'd0) begin bad++; $display("[TB] FAIL rst_pulse_fields got ctl=%h dest=%0d want 0/0", bus.AluControl, bus.dest); end
    endtask

    // Random traffic with random stalls and occasional flushes against a queue model.
    task automatic test_random();
        exp_t q[$];
        exp_t last;
        exp_t e;
        logic acc;
        logic pop;
        resetn = 1'b0;
        bus.in_valid = 1'b0;
        bus.flush = 1'b0;
        tick();
        resetn = 1'b1;
        #1;
        last = '{32'h0, 32'h0, 5'd0, 4'h0, 5'd0, 1'b0};
        for (int i = 0; i < 400; i++) begin
            e = (q.size() > 0) ? q[0] : last;
            last = e;
            total++; if (bus.out_valid !== (q.size() != 0)) begin bad++; $display("[TB] FAIL rnd_valid cyc=%0d got=%b want=%b", i, bus.out_valid, q.size() != 0); end
            total++; if (bus.in_ready !== (q.size() < 2)) begin bad++; $display("[TB] FAIL rnd_in_ready cyc=%0d got=%b want=%b", i, bus.in_ready, q.size() < 2); end
            total++; if (bus.AluControl !== e.ctl || bus.ill !== e.ill || bus.dest !== e.dest || bus.SrcA !== e.a) begin bad++; $display("[TB] FAIL rnd_head cyc=%0d got ctl=%h ill=%b dest=%0d a=%h want %h/%b/%0d/%h", i, bus.AluControl, bus.ill, bus.dest, bus.SrcA, e.ctl, e.ill, e.dest, e.a); end
            if (!e.ill) begin
                total++; if (bus.SrcB !== e.b || bus.Sa !== e.sa) begin bad++; $display("[TB] FAIL rnd_opnd cyc=%0d got b=%h sa=%0d want %h/%0d", i, bus.SrcB, bus.Sa, e.b, e.sa); end
            end
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            bus.flush = ($urandom_range(0, 19) == 0);
            bus.instr = rand_instr();
            bus.rs_val = $urandom;
            bus.rt_val = $urandom;
            acc = bus.in_valid && (q.size() < 2);
            pop = (q.size() > 0) && bus.out_ready;
            if (bus.flush) begin
                q.delete();
            end else begin
                if (pop) void'(q.pop_front());
                if (acc) q.push_back(model_decode(bus.instr, bus.rs_val, bus.rt_val));
            end
            tick();
        end
        bus.in_valid = 1'b0;
        bus.flush = 1'b0;
    endtask

    initial begin
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.instr = 32'h0;
        bus.rs_val = 32'h0;
        bus.rt_val = 32'h0;
        bus.out_ready = 1'b0;
        #1;
        test_reset();
        test_addiu();
        test_sra_lui();
        test_backpressure();
        test_flush();
        test_illegal_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
